// File: rtl/multicycle_ctrl.sv
// Multi-cycle CPU control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing plus retire counter.
// Optional ILLEGAL_TRAP_EN: unknown opcode1 halts the core instead of executing as a NOP.
module multicycle_ctrl #(
    parameter int CNT_BITS = 32,
    parameter int MEM_TO   = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [3:0]          opcode1,
    input  logic [3:0]          opcode2,
    input  logic                cond_true,
    input  logic                mem_rdy,
    output logic                ir_we,
    output logic                pc_we,
    output logic [1:0]          pc_sel,
    output logic                alu_imm,
    output logic [3:0]          alu_op,
    output logic                reg_we,
    output logic [1:0]          wb_sel,
    output logic                mem_re,
    output logic                mem_we,
    output logic                mem_err,
    output logic [CNT_BITS-1:0] inst_cnt,
    output logic                busy
);

    localparam int TW = (MEM_TO > 1) ? $clog2(MEM_TO + 1) : 1;

    localparam logic [3:0] OP_ALUR  = 4'h0;
    localparam logic [3:0] OP_ALUI  = 4'h1;
    localparam logic [3:0] OP_CMPR  = 4'h2;
    localparam logic [3:0] OP_CMPI  = 4'h3;
    localparam logic [3:0] OP_BCOND = 4'h4;
    localparam logic [3:0] OP_LW    = 4'h5;
    localparam logic [3:0] OP_SW    = 4'h6;
    localparam logic [3:0] OP_JAL   = 4'h7;

    typedef enum logic [2:0] {
        S_RST, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    state_t        state;
    state_t        next;
    logic [TW-1:0] to_cnt;
    logic          to_hit;
    logic          retire;
    logic          is_lw;
    logic          is_sw;
    logic          is_jal;
    logic          is_bcond;
    logic          is_imm;
    logic          known;

    assign is_lw    = (opcode1 == OP_LW);
    assign is_sw    = (opcode1 == OP_SW);
    assign is_jal   = (opcode1 == OP_JAL);
    assign is_bcond = (opcode1 == OP_BCOND);
    assign is_imm   = (opcode1 == OP_ALUI) || (opcode1 == OP_CMPI)
                   || is_lw || is_sw || is_jal;
    assign known    = (opcode1 == OP_ALUR) || (opcode1 == OP_CMPR)
                   || is_imm || is_bcond;

    // MEM_TO of zero disables the timeout entirely
    assign to_hit = (MEM_TO != 0) && (to_cnt == TW'(MEM_TO));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_RST;
            to_cnt   <= '0;
            mem_err  <= 1'b0;
            inst_cnt <= '0;
        end else begin
            state <= next;
            if (state != S_MEM)
                to_cnt <= '0;
            else if (!mem_rdy && !to_hit)
                to_cnt <= to_cnt + TW'(1);
            if (state == S_MEM && !mem_rdy && to_hit)
                mem_err <= 1'b1;
            if (retire)
                inst_cnt <= inst_cnt + CNT_BITS'(1);
        end
    end

    always_comb begin
        next    = state;
        ir_we   = 1'b0;
        pc_we   = 1'b0;
        pc_sel  = 2'd0;
        alu_imm = 1'b0;
        alu_op  = 4'd0;
        reg_we  = 1'b0;
        wb_sel  = 2'd0;
        mem_re  = 1'b0;
        mem_we  = 1'b0;
        retire  = 1'b0;
        unique case (state)
            S_RST: next = S_FETCH;
            S_FETCH: begin
                ir_we = 1'b1;
                next  = S_DECODE;
            end
            S_DECODE: begin
`ifdef ILLEGAL_TRAP_EN
                next = known ? S_EXEC : S_HALT;
`else
                next = S_EXEC;
`endif
            end
            S_EXEC: begin
                alu_imm = is_imm;
                alu_op  = (is_lw || is_sw || is_jal || !known) ? 4'd0 : opcode2;
                unique case (1'b1)
                    is_bcond: begin
                        pc_we  = 1'b1;
                        pc_sel = cond_true ? 2'd1 : 2'd0;
                        retire = 1'b1;
                        next   = S_FETCH;
                    end
                    is_lw || is_sw: next = S_MEM;
                    !known: begin
                        pc_we  = 1'b1;
                        retire = 1'b1;
                        next   = S_FETCH;
                    end
                    default: next = S_WB;
                endcase
            end
            S_MEM: begin
                // strobes are held through the completing cycle, dropped on timeout
                mem_re = is_lw && (mem_rdy || !to_hit);
                mem_we = !is_lw && (mem_rdy || !to_hit);
                if (mem_rdy) begin
                    if (is_lw) begin
                        next = S_WB;
                    end else begin
                        pc_we  = 1'b1;
                        retire = 1'b1;
                        next   = S_FETCH;
                    end
                end else if (to_hit) begin
                    pc_we  = 1'b1;
                    retire = 1'b1;
                    next   = S_FETCH;
                end
            end
            S_WB: begin
                reg_we = 1'b1;
                pc_we  = 1'b1;
                retire = 1'b1;
                wb_sel = is_lw ? 2'd1 : (is_jal ? 2'd2 : 2'd0);
                pc_sel = is_jal ? 2'd2 : 2'd0;
                next   = S_FETCH;
            end
            S_HALT: next = S_HALT;
            default: next = S_RST;
        endcase
    end

    assign busy = (state != S_RST) && (state != S_HALT);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: table of instructions plus reset/timeout/trap sequences.
// Opcode1 map: ALUR 0, ALUI 1, CMPR 2, CMPI 3, BCOND 4, LW 5, SW 6, JAL 7.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  opcode1;
    logic [3:0]  opcode2;
    logic        cond_true;
    logic        mem_rdy;
    logic        ir_we;
    logic        pc_we;
    logic [1:0]  pc_sel;
    logic        alu_imm;
    logic [3:0]  alu_op;
    logic        reg_we;
    logic [1:0]  wb_sel;
    logic        mem_re;
    logic        mem_we;
    logic        mem_err;
    logic [31:0] inst_cnt;
    logic        busy;

    int n_pass = 0;
    int n_tot  = 0;

    multicycle_ctrl dut (
        .clk(clk), .reset(reset), .opcode1(opcode1), .opcode2(opcode2),
        .cond_true(cond_true), .mem_rdy(mem_rdy), .ir_we(ir_we),
        .pc_we(pc_we), .pc_sel(pc_sel), .alu_imm(alu_imm), .alu_op(alu_op),
        .reg_we(reg_we), .wb_sel(wb_sel), .mem_re(mem_re), .mem_we(mem_we),
        .mem_err(mem_err), .inst_cnt(inst_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] op1;
        logic [3:0] op2;
        logic       cond;
        logic       idle;
        int         wt;
        int         lat;
        int         re;
        int         we;
        int         rw;
        int         wb;
        int         ps;
        int         imm;
        int         aop;
        int         err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(int op1, int op2, int cond, int idle, int wt,
                                int lat, int re, int we, int rw, int wb,
                                int ps, int imm, int aop, int err);
        vec_t v;
        v.op1 = 4'(op1); v.op2 = 4'(op2);
        v.cond = 1'(cond); v.idle = 1'(idle); v.wt = wt;
        v.lat = lat; v.re = re; v.we = we; v.rw = rw; v.wb = wb;
        v.ps = ps; v.imm = imm; v.aop = aop; v.err = err;
        return v;
    endfunction

    task automatic chk(string name, int got, int exp);
        n_tot++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    // Entered and left one #1 after a negedge with the DUT in FETCH.
    task automatic run_vec(vec_t v, int k);
        int lat = -1;
        int re = 0, we = 0, rw = 0, pw = 0;
        int wb = 0, ps = 0, imm = -1, aop = -1, mcyc = 0;
        logic [31:0] c0;
        c0 = inst_cnt;
        opcode1   = v.op1;
        opcode2   = v.op2;
        cond_true = v.cond;
        mem_rdy   = v.idle;
        for (int i = 1; i < 400; i++) begin
            @(negedge clk);
            if (mem_re || mem_we) begin
                mem_rdy = (v.wt >= 0) && (mcyc == v.wt);
                mcyc++;
            end else begin
                mem_rdy = v.idle;
            end
            #1;
            if (i == 2) begin
                imm = int'(alu_imm);
                aop = int'(alu_op);
            end
            if (mem_re) re++;
            if (mem_we) we++;
            if (reg_we) begin rw++; wb = int'(wb_sel); end
            if (pc_we)  begin pw++; ps = int'(pc_sel); end
            if (ir_we) begin lat = i; break; end
        end
        if (lat < 0) $display("FAIL v%0d no return to fetch within budget", k);
        chk($sformatf("v%0d latency", k), lat, v.lat);
        chk($sformatf("v%0d mem_re cycles", k), re, v.re);
        chk($sformatf("v%0d mem_we cycles", k), we, v.we);
        chk($sformatf("v%0d reg_we cycles", k), rw, v.rw);
        chk($sformatf("v%0d wb_sel", k), wb, v.wb);
        chk($sformatf("v%0d pc_we cycles", k), pw, 1);
        chk($sformatf("v%0d pc_sel", k), ps, v.ps);
        chk($sformatf("v%0d alu_imm", k), imm, v.imm);
        chk($sformatf("v%0d alu_op", k), aop, v.aop);
        chk($sformatf("v%0d inst_cnt delta", k), int'(inst_cnt - c0), 1);
        chk($sformatf("v%0d mem_err", k), int'(mem_err), v.err);
    endtask

    initial begin
        reset = 1'b0; opcode1 = '0; opcode2 = '0;
        cond_true = 1'b0; mem_rdy = 1'b0;

        //            op1 op2 cnd idl wt  lat re we rw wb ps imm aop err
        vecs.push_back(mk(0, 0, 0, 0, 0,  4, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 5, 1, 1, 0,  4, 0, 0, 1, 0, 0, 0, 5, 0));
        vecs.push_back(mk(1, 3, 0, 0, 0,  4, 0, 0, 1, 0, 0, 1, 3, 0));
        vecs.push_back(mk(2, 8, 1, 0, 0,  4, 0, 0, 1, 0, 0, 0, 8, 0));
        vecs.push_back(mk(3, 9, 0, 1, 0,  4, 0, 0, 1, 0, 0, 1, 9, 0));
        vecs.push_back(mk(4, 2, 1, 0, 0,  3, 0, 0, 0, 0, 1, 0, 2, 0));
        vecs.push_back(mk(4, 2, 0, 1, 0,  3, 0, 0, 0, 0, 0, 0, 2, 0));
        vecs.push_back(mk(5, 7, 0, 0, 0,  5, 1, 0, 1, 1, 0, 1, 0, 0));
        vecs.push_back(mk(5, 7, 1, 1, 2,  7, 3, 0, 1, 1, 0, 1, 0, 0));
        vecs.push_back(mk(6, 3, 0, 0, 0,  4, 0, 1, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(6, 3, 0, 1, 1,  5, 0, 2, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(7, 4, 1, 0, 0,  4, 0, 0, 1, 2, 2, 1, 0, 0));
`ifndef ILLEGAL_TRAP_EN
        vecs.push_back(mk(15, 6, 1, 1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0));
`endif
        // LW that never completes: 255 wait cycles then the timeout cycle
        vecs.push_back(mk(5, 1, 0, 0, -1, 259, 255, 0, 0, 0, 0, 1, 0, 1));

        repeat (3) @(negedge clk);
        #1;
        chk("reset outputs", int'({ir_we, pc_we, pc_sel, alu_imm, alu_op, reg_we,
                                   wb_sel, mem_re, mem_we, mem_err, busy}), 0);
        chk("reset inst_cnt", int'(inst_cnt), 0);
        reset = 1'b1;
        #1;
        chk("S_RST after release ir_we", int'(ir_we), 0);
        @(negedge clk);
        #1;
        chk("first fetch ir_we", int'(ir_we), 1);
        chk("first fetch busy", int'(busy), 1);

        foreach (vecs[k]) run_vec(vecs[k], k);

        // reset asserted while SW waits in MEM
        opcode1 = 4'h6; opcode2 = 4'h0; mem_rdy = 1'b0; cond_true = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("sw mem_we before reset", int'(mem_we), 1);
        #2;
        reset = 1'b0;
        #1;
        chk("sw mem_we after async reset", int'(mem_we), 0);
        chk("busy after async reset", int'(busy), 0);
        chk("inst_cnt after async reset", int'(inst_cnt), 0);
        chk("mem_err cleared by reset", int'(mem_err), 0);
        @(negedge clk);
        #1;
        chk("held reset ir_we", int'(ir_we), 0);
        reset = 1'b1;
        @(negedge clk);
        #1;
        chk("fetch after release", int'(ir_we), 1);

`ifdef ILLEGAL_TRAP_EN
        opcode1 = 4'hF;
        begin
            int act = 0;
            repeat (2) @(negedge clk);
            #1;
            chk("halt busy", int'(busy), 0);
            repeat (6) begin
                @(negedge clk);
                #1;
                act += int'(ir_we | pc_we | reg_we | mem_re | mem_we | busy);
            end
            chk("halt stays idle", act, 0);
        end
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        chk("fetch after halt reset", int'(ir_we), 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
